// File: rtl/crc8_frame_checker_if.sv
// crc8_frame_checker_if
// Groups the byte-stream input handshake, the payload output stream and the
// per-frame verdict of crc8_frame_checker.
//   valid_i/data_i/last_i : input byte stream (driven by the deserializer side)
//   ready_o               : checker can accept a byte this cycle
//   valid_o/data_o/last_o : payload stream with the CRC byte stripped
//   status_valid_o        : one-cycle verdict pulse
//   crc_ok_o/len_err_o/frame_len_o : verdict, valid only with status_valid_o
// Handshake: an input byte is transferred on a rising edge where
// valid_i && ready_o. The output stream has no backpressure; each valid_o
// cycle is exactly one byte.
interface crc8_frame_checker_if;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        last_i;
  logic        ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        last_o;
  logic        status_valid_o;
  logic        crc_ok_o;
  logic        len_err_o;
  logic [15:0] frame_len_o;

  // Checker side.
  modport slave (
    input  valid_i, data_i, last_i,
    output ready_o, valid_o, data_o, last_o,
    output status_valid_o, crc_ok_o, len_err_o, frame_len_o
  );

  // Stream source / payload sink side.
  modport master (
    output valid_i, data_i, last_i,
    input  ready_o, valid_o, data_o, last_o,
    input  status_valid_o, crc_ok_o, len_err_o, frame_len_o
  );
endinterface

// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker
// Receive-side CRC-8/EBU frame checker. Every accepted byte, including the
// trailing CRC byte, is folded into a reflected CRC register; a good frame
// leaves residue 0x00. The payload is forwarded through a one-byte hold
// register so the CRC byte is never emitted, and a one-cycle verdict is
// reported per frame.
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   soft_reset_i : synchronous clear, outranks an input byte; also blanks outputs
//   bus          : stream/verdict interface (slave modport)
//   state_dbg_o  : current FSM state (0 IDLE, 1 BODY, 2 STATUS)
module crc8_frame_checker #(
  parameter logic [7:0] POLY_REFL = 8'hB8,
  parameter logic [7:0] INIT      = 8'hFF,
  parameter int         MAX_LEN   = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     soft_reset_i,
  crc8_frame_checker_if.slave      bus,
  output logic [1:0]               state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BODY   = 2'd1,
    STATUS = 2'd2
  } state_e;

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_e      state_q, state_d;
  logic [7:0]  crc_q;
  logic [15:0] len_q;
  logic        hold_valid_q;
  logic [7:0]  hold_data_q;

  logic        valid_q, last_q, status_q, ok_q, len_err_q;
  logic [7:0]  data_q;
  logic [15:0] flen_q;

  logic        accept;
  logic [7:0]  crc_next;
  logic [15:0] len_next;
  logic        len_err_next;

  // LSB-first fold of one byte into the reflected CRC register.
  function automatic logic [7:0] crc_fold(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ POLY_REFL;
    end
    return r;
  endfunction

  assign accept       = bus.valid_i && (state_q != STATUS) && !soft_reset_i;
  assign crc_next     = crc_fold(crc_q, bus.data_i);
  assign len_next     = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  assign len_err_next = (len_next < 16'd2) || ({1'b0, len_next} > MAX_LEN_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, BODY: if (accept) state_d = bus.last_i ? STATUS : BODY;
      STATUS:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           state_q <= IDLE;
    else if (soft_reset_i) state_q <= IDLE;
    else                   state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q        <= INIT;
      len_q        <= 16'd0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'd0;
      valid_q      <= 1'b0;
      data_q       <= 8'd0;
      last_q       <= 1'b0;
      status_q     <= 1'b0;
      ok_q         <= 1'b0;
      len_err_q    <= 1'b0;
      flen_q       <= 16'd0;
    end else if (soft_reset_i) begin
      crc_q        <= INIT;
      len_q        <= 16'd0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'd0;
      valid_q      <= 1'b0;
      data_q       <= 8'd0;
      last_q       <= 1'b0;
      status_q     <= 1'b0;
      ok_q         <= 1'b0;
      len_err_q    <= 1'b0;
      flen_q       <= 16'd0;
    end else begin
      // Output and verdict registers are single-cycle pulses.
      valid_q   <= 1'b0;
      data_q    <= 8'd0;
      last_q    <= 1'b0;
      status_q  <= 1'b0;
      ok_q      <= 1'b0;
      len_err_q <= 1'b0;
      flen_q    <= 16'd0;
      if (state_q == STATUS) begin
        crc_q        <= INIT;
        len_q        <= 16'd0;
        hold_valid_q <= 1'b0;
      end else if (accept) begin
        crc_q <= crc_next;
        len_q <= len_next;
        // The held byte is released only once a following byte arrives,
        // which is what keeps the trailing CRC byte off the output.
        if (hold_valid_q) begin
          valid_q <= 1'b1;
          data_q  <= hold_data_q;
          last_q  <= bus.last_i;
        end
        if (bus.last_i) begin
          hold_valid_q <= 1'b0;
          status_q     <= 1'b1;
          len_err_q    <= len_err_next;
          ok_q         <= (crc_next == 8'h00) && !len_err_next;
          flen_q       <= len_next - 16'd1;
        end else begin
          hold_valid_q <= 1'b1;
          hold_data_q  <= bus.data_i;
        end
      end
    end
  end

  // soft_reset_i blanks whatever the registers present in its cycle.
  assign bus.ready_o        = soft_reset_i || (state_q != STATUS);
  assign bus.valid_o        = valid_q   && !soft_reset_i;
  assign bus.data_o         = soft_reset_i ? 8'd0 : data_q;
  assign bus.last_o         = last_q    && !soft_reset_i;
  assign bus.status_valid_o = status_q  && !soft_reset_i;
  assign bus.crc_ok_o       = ok_q      && !soft_reset_i;
  assign bus.len_err_o      = len_err_q && !soft_reset_i;
  assign bus.frame_len_o    = soft_reset_i ? 16'd0 : flen_q;
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb_crc8_frame_checker
// Drives two checkers (MAX_LEN 256 and MAX_LEN 4) with directed and random
// frames. Expected payload bytes and verdicts are queued when a frame is
// issued and popped by a monitor whenever a checker presents output.
module tb_crc8_frame_checker;

  logic clk;
  logic rst_n;
  logic soft_reset;
  logic [1:0] state_a, state_b;

  crc8_frame_checker_if ifa();
  crc8_frame_checker_if ifb();

  crc8_frame_checker #(.MAX_LEN(256)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .soft_reset_i(soft_reset),
    .bus(ifa), .state_dbg_o(state_a)
  );

  crc8_frame_checker #(.MAX_LEN(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .soft_reset_i(soft_reset),
    .bus(ifb), .state_dbg_o(state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: payload entries are {last, data}; verdicts are {ok, len_err, frame_len}.
  logic [8:0]  pay_q0[$];
  logic [8:0]  pay_q1[$];
  logic [17:0] stat_q0[$];
  logic [17:0] stat_q1[$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // CRC-8/EBU computed the textbook way: MSB-first polynomial 0x1D on
  // bit-reversed bytes, result reversed back.
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [7:0] r;
    r = rev8(8'hFF);
    foreach (msg[k]) begin
      r = r ^ rev8(msg[k]);
      for (int j = 0; j < 8; j++) r = r[7] ? ((r << 1) ^ 8'h1D) : (r << 1);
    end
    return rev8(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic check_out(input int sel, input logic v, input logic [7:0] d, input logic l,
                           input logic sv, input logic ok, input logic le, input logic [15:0] fl);
    logic [8:0]  e;
    logic [17:0] es;
    int          sz;
    if (v) begin
      total++;
      sz = (sel == 0) ? pay_q0.size() : pay_q1.size();
      if (sz == 0) begin
        bad++;
        $display("FAIL payload%0d unexpected: got last=%b data=%h required no byte", sel, l, d);
      end else begin
        e = (sel == 0) ? pay_q0.pop_front() : pay_q1.pop_front();
        if ({l, d} !== e) begin
          bad++;
          $display("FAIL payload%0d: got last=%b data=%h required last=%b data=%h", sel, l, d, e[8], e[7:0]);
        end
      end
    end
    total++;
    if (sv) begin
      sz = (sel == 0) ? stat_q0.size() : stat_q1.size();
      if (sz == 0) begin
        bad++;
        $display("FAIL status%0d unexpected: got ok=%b len_err=%b len=%0d required no status", sel, ok, le, fl);
      end else begin
        es = (sel == 0) ? stat_q0.pop_front() : stat_q1.pop_front();
        if ({ok, le, fl} !== es) begin
          bad++;
          $display("FAIL status%0d: got ok=%b len_err=%b len=%0d required ok=%b len_err=%b len=%0d",
                   sel, ok, le, fl, es[17], es[16], es[15:0]);
        end
      end
    end else if ({ok, le, fl} !== 18'd0) begin
      bad++;
      $display("FAIL verdict_idle%0d: got ok=%b len_err=%b len=%0d required all 0", sel, ok, le, fl);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_out(0, ifa.valid_o, ifa.data_o, ifa.last_o, ifa.status_valid_o,
                ifa.crc_ok_o, ifa.len_err_o, ifa.frame_len_o);
      check_out(1, ifb.valid_o, ifb.data_o, ifb.last_o, ifb.status_valid_o,
                ifb.crc_ok_o, ifb.len_err_o, ifb.frame_len_o);
    end
  end

  // ---------------- driver ----------------
  task automatic set_in(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin
      ifa.valid_i = v; ifa.data_i = d; ifa.last_i = l;
    end else begin
      ifb.valid_i = v; ifb.data_i = d; ifb.last_i = l;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ifa.ready_o : ifb.ready_o;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic drive_byte(input int sel, input logic [7:0] d, input logic l,
                            input int gap_max, output int waited);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    if (g > 0) begin
      set_in(sel, 1'b0, 8'd0, 1'b0);
      repeat (g) begin @(posedge clk); #1; end
    end
    set_in(sel, 1'b1, d, l);
    waited = 0;
    @(negedge clk);
    while (!get_ready(sel) && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 1000) begin
      total++; bad++;
      $display("FAIL accept_timeout%0d: got no ready in 1000 cycles required ready", sel);
    end
    @(posedge clk); #1;
  endtask

  task automatic push_expect(input int sel, input logic [7:0] f[$], input int max_len);
    int n;
    logic [7:0] payload[$];
    logic le, ok;
    n = f.size();
    payload = {};
    for (int i = 0; i < n - 1; i++) begin
      payload.push_back(f[i]);
      if (sel == 0) pay_q0.push_back({(i == n - 2), f[i]});
      else          pay_q1.push_back({(i == n - 2), f[i]});
    end
    le = (n < 2) || (n > max_len);
    ok = !le && (f[n-1] == model_crc(payload));
    if (sel == 0) stat_q0.push_back({ok, le, 16'(n - 1)});
    else          stat_q1.push_back({ok, le, 16'(n - 1)});
  endtask

  task automatic send_frame(input int sel, input logic [7:0] f[$], input int gap_max,
                            output int first_wait);
    int w;
    push_expect(sel, f, (sel == 0) ? 256 : 4);
    first_wait = 0;
    foreach (f[i]) begin
      drive_byte(sel, f[i], (i == f.size() - 1), gap_max, w);
      if (i == 0) first_wait = w;
    end
  endtask

  task automatic idle(input int cycles);
    set_in(0, 1'b0, 8'd0, 1'b0);
    set_in(1, 1'b0, 8'd0, 1'b0);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  function automatic void rand_frame(input int len, output logic [7:0] f[$]);
    f = {};
    for (int i = 0; i < len - 1; i++) f.push_back(8'($urandom_range(0, 255)));
    if ($urandom_range(0, 1) == 1) f.push_back(model_crc(f));
    else                           f.push_back(8'($urandom_range(0, 255)));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] f1[$];
    logic [7:0] f[$];
    int w;

    rst_n = 1'b0;
    soft_reset = 1'b0;
    set_in(0, 1'b0, 8'd0, 1'b0);
    set_in(1, 1'b0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    chk("rst_ready", {31'd0, ifa.ready_o}, 32'd1);
    chk("rst_valid", {31'd0, ifa.valid_o}, 32'd0);
    chk("rst_data", {24'd0, ifa.data_o}, 32'd0);
    chk("rst_status", {31'd0, ifa.status_valid_o}, 32'd0);
    chk("rst_flen", {16'd0, ifa.frame_len_o}, 32'd0);
    chk("rst_state", {30'd0, state_a}, 32'd0);
    chk("rst_ready_b", {31'd0, ifb.ready_o}, 32'd1);

    // Known-good frame "123456789" + 0x97.
    f1 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h97};
    send_frame(0, f1, 0, w);
    idle(3);

    // Corrupted byte 35 -> 34.
    f = f1; f[4] = 8'h34;
    send_frame(0, f, 0, w);
    idle(3);

    // Short frame with random gaps.
    f = {8'hFF, 8'hFF, 8'h23};
    send_frame(0, f, 3, w);
    idle(3);

    // Single byte frame.
    f = {8'h5A};
    send_frame(0, f, 0, w);
    idle(3);

    // Oversize frame on the MAX_LEN=4 checker, correct CRC.
    f = {};
    for (int i = 0; i < 5; i++) f.push_back(8'($urandom_range(0, 255)));
    f.push_back(model_crc(f));
    send_frame(1, f, 1, w);
    idle(3);
    for (int k = 0; k < 12; k++) begin
      rand_frame(int'($urandom_range(1, 7)), f);
      send_frame(1, f, 2, w);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(3);

    // Async reset after three bytes: two bytes escape the hold register.
    pay_q0.push_back({1'b0, 8'h11});
    pay_q0.push_back({1'b0, 8'h22});
    drive_byte(0, 8'h11, 1'b0, 0, w);
    drive_byte(0, 8'h22, 1'b0, 0, w);
    drive_byte(0, 8'h33, 1'b0, 0, w);
    set_in(0, 1'b0, 8'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(0, f1, 0, w);
    idle(3);

    // Back-to-back frames with valid held high: exactly one bubble.
    send_frame(0, f1, 0, w);
    send_frame(0, f1, 0, w);
    chk("b2b_bubble", w, 32'd1);
    idle(3);

    // Soft reset during STATUS: last payload byte and verdict are suppressed.
    f = {8'hA1, 8'hB2, 8'hC3};
    f.push_back(model_crc(f));
    pay_q0.push_back({1'b0, 8'hA1});
    pay_q0.push_back({1'b0, 8'hB2});
    foreach (f[i]) drive_byte(0, f[i], (i == 3), 0, w);
    set_in(0, 1'b0, 8'd0, 1'b0);
    soft_reset = 1'b1;
    #1;
    chk("soft_rst_ready", {31'd0, ifa.ready_o}, 32'd1);
    chk("soft_rst_status", {31'd0, ifa.status_valid_o}, 32'd0);
    @(posedge clk); #1;
    soft_reset = 1'b0;
    chk("soft_rst_state", {30'd0, state_a}, 32'd0);
    send_frame(0, f, 0, w);
    idle(3);

    // Random frames.
    for (int k = 0; k < 40; k++) begin
      rand_frame(int'($urandom_range(1, 24)), f);
      send_frame(0, f, 2, w);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(10);

    chk("left_payload_a", pay_q0.size(), 32'd0);
    chk("left_status_a", stat_q0.size(), 32'd0);
    chk("left_payload_b", pay_q1.size(), 32'd0);
    chk("left_status_b", stat_q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
